// File: rtl/gpio_in_capture.sv
// gpio_in_capture: pad-side synchroniser, per-bit edge/level event detection and sticky interrupt status.
// Define GPIO_DEBOUNCE_EN to insert a per-bit stability filter (DEB_CYCLES) after the synchroniser.
module gpio_in_capture #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic                  pclk,
    input  logic                  p_reset,
    input  logic [DATA_WIDTH-1:0] gpio_pin_in,
    input  logic [DATA_WIDTH-1:0] n_gpio_pin_oe,
    input  logic [DATA_WIDTH-1:0] int_en,
    input  logic [DATA_WIDTH-1:0] int_type,
    input  logic [DATA_WIDTH-1:0] int_pol,
    input  logic                  clr_valid,
    input  logic [DATA_WIDTH-1:0] clr_mask,
    output logic [DATA_WIDTH-1:0] gpio_in_sync,
    output logic [DATA_WIDTH-1:0] int_status,
    output logic                  gpio_int
);

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned FLUSH_CYCLES = SYNC_STAGES + 1 + DEB_CYCLES;
`else
    localparam int unsigned FLUSH_CYCLES = SYNC_STAGES + 1;
`endif
    // Counter sized for the longest flush either build can need.
    localparam int unsigned FCW = $clog2(SYNC_STAGES + DEB_CYCLES + 2);

    typedef enum logic {
        FLUSH,
        ACTIVE
    } arm_state_e;

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0] sync_raw;
    logic [DATA_WIDTH-1:0] filt;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic                  int_q, int_d;
    arm_state_e            arm_state_q, arm_state_d;
    logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;

    logic [DATA_WIDTH-1:0] rise, fall, edge_hit, level_hit, evt, clr;
    logic                  armed;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], gpio_pin_in};
        sync_raw = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DATA_WIDTH-1:0][3:0] deb_cnt_q, deb_cnt_d;
    logic [DATA_WIDTH-1:0]      filt_q, filt_d;

    // Any sample equal to the filtered value restarts the stability count.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        filt_d    = filt_q;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (sync_raw[i] == filt_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == 4'(DEB_CYCLES - 1)) begin
                filt_d[i]    = sync_raw[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            deb_cnt_q <= '0;
            filt_q    <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            filt_q    <= filt_d;
        end
    end

    always_comb filt = filt_q;
`else
    always_comb filt = sync_raw;
`endif

    always_comb begin
        arm_state_d = arm_state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (arm_state_q)
            FLUSH: begin
                if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
                    arm_state_d = ACTIVE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end
            ACTIVE: begin
                arm_state_d = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            arm_state_q <= FLUSH;
            flush_cnt_q <= '0;
        end else begin
            arm_state_q <= arm_state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // prev follows the filtered value even for self-driven pins, so re-enabling capture cannot fake an edge.
    always_comb begin
        armed     = (arm_state_q == ACTIVE);
        rise      = filt & ~prev_q;
        fall      = ~filt & prev_q;
        edge_hit  = (int_pol & rise) | (~int_pol & fall);
        level_hit = (int_pol & filt) | (~int_pol & ~filt);
        evt       = ((int_type & edge_hit) | (~int_type & level_hit))
                    & n_gpio_pin_oe & {DATA_WIDTH{armed}};
        clr       = clr_valid ? clr_mask : '0;
        status_d  = (status_q & ~clr) | evt;
        int_d     = |(status_q & int_en);
        prev_d    = filt;
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            prev_q   <= '0;
            status_q <= '0;
            int_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            status_q <= status_d;
            int_q    <= int_d;
        end
    end

    assign gpio_in_sync = filt;
    assign int_status   = status_q;
    assign gpio_int     = int_q;

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Pin-side reader for the GPIO block: samples gpio_pin_in, the return direction of gpio_pin_out/n_gpio_pin_oe.
- Synchronises the inputs into pclk, detects edge or level events per bit, and holds sticky interrupt status.
- Drives a single interrupt line.
- Sits between the pads and the GPIO APB register file; the register file supplies the config and clear pulses.

Parameters:
- DATA_WIDTH, 16, number of GPIO bits; matches the GPIO data width define.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- DEB_CYCLES, 4, debounce stability count; used only with GPIO_DEBOUNCE_EN; legal range 2..15.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- p_reset  in  1  synchronous active-high reset.
- gpio_pin_in  in  DATA_WIDTH  raw asynchronous pad inputs.
- n_gpio_pin_oe  in  DATA_WIDTH  output enable, active-low; a 0 bit means the pin is self-driven and is excluded from event capture.
- int_en  in  DATA_WIDTH  per-bit interrupt enable.
- int_type  in  DATA_WIDTH  per-bit mode: 1 = edge, 0 = level.
- int_pol  in  DATA_WIDTH  per-bit polarity: edge mode 1 = rising, 0 = falling; level mode 1 = high, 0 = low.
- clr_valid  in  1  single-cycle clear strobe.
- clr_mask  in  DATA_WIDTH  write-1-to-clear mask, qualified by clr_valid.
- gpio_in_sync  out  DATA_WIDTH  synchronised (and filtered) pin values.
- int_status  out  DATA_WIDTH  sticky per-bit event status.
- gpio_int  out  1  registered interrupt, equal to OR of (int_status & int_en).

Behaviour:
- Interface: one clock, pclk. Reset p_reset is synchronous and active-high.
- Reset values: gpio_in_sync = 0, int_status = 0, gpio_int = 0. Synchroniser, previous-value register and debounce state are cleared to 0.
- Reset mid-operation: takes effect at the next pclk edge regardless of pending events or clears. Status is lost.
- Synchroniser: a SYNC_STAGES flop chain per bit. A pin change set up before edge k appears on gpio_in_sync after edge k+SYNC_STAGES-1.
- prev register holds gpio_in_sync delayed by one cycle.
- Edge events:
  - rise = sync & ~prev
  - fall = ~sync & prev
- Per-bit event:
  - edge mode: int_pol ? rise : fall
  - level mode: int_pol ? sync : ~sync
  - The event is then ANDed with n_gpio_pin_oe and with the arm flag.
- Arm FSM: two states, FLUSH and ACTIVE.
  - Reset puts it in FLUSH with a counter at 0.
  - FLUSH counts SYNC_STAGES+1 cycles (plus DEB_CYCLES when debounce is compiled in), then moves to ACTIVE.
  - ACTIVE is held until reset.
  - Events are suppressed in FLUSH, so post-reset pin levels never produce spurious edges.
- Status update each cycle: int_status <= (int_status & ~(clr_valid ? clr_mask : 0)) | event.
  - Set wins over a simultaneous clear of the same bit.
  - Level mode: the bit re-sets every cycle while the level is active, so a clear is effective only once the level is gone.
- int_en gates only gpio_int; status is captured regardless of enable.
- gpio_int is registered from the current int_status, one cycle after it.
- End-to-end edge latency from pin change before edge k:
  - status set at edge k+SYNC_STAGES
  - gpio_int at edge k+SYNC_STAGES+1
- Pulses shorter than one pclk period may be missed. No pulse-stretching is required.
- Config changes (int_type, int_pol, int_en) act from the next cycle and never modify existing status.
- A bit whose n_gpio_pin_oe goes 0→1: prev keeps tracking throughout, so no false edge is generated on the transition.
- clr_mask bits of 0 have no effect; clr_valid=0 ignores clr_mask.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Each bit gets a 4-bit stability counter after the synchroniser.
  - The filtered value updates only after the synchronised value differs from the current filtered value for DEB_CYCLES consecutive cycles.
  - Any bounce back to the filtered value resets the counter to 0.
  - gpio_in_sync and all event logic use the filtered value; latency grows by DEB_CYCLES.
- Undefined: filtered value equals the synchroniser output, with no counters and no added latency.

Test Plan:
- Reset flush: hold gpio_pin_in=16'hFFFF through reset, all bits edge/rising, int_en=16'hFFFF → int_status stays 0 and gpio_int=0 after release; gpio_in_sync=16'hFFFF after SYNC_STAGES cycles.
- Rising edge latency: bit 3 0→1 before edge k, edge/rising, int_en[3]=1 → int_status=16'h0008 at k+2, gpio_int=1 at k+3. Then clr_valid with clr_mask=16'h0008 → status 0 next cycle, gpio_int 0 the cycle after.
- Level mode with clear-vs-set: bit 0 level-high held at 1, clear pulsed → int_status[0] stays 1. Drop pin, wait 3 cycles, clear → int_status[0]=0.
- Output masking: n_gpio_pin_oe=16'hFFFE, toggle bit 0 pin → int_status[0] never sets. Set n_gpio_pin_oe[0]=1 while the pin is steady → no event.
- Enable gating: bit 5 falling edge with int_en[5]=0 → int_status=16'h0020 and gpio_int=0. Then set int_en[5]=1 → gpio_int=1 one cycle later.
- GPIO_DEBOUNCE_EN, DEB_CYCLES=4: bit 7 pulse 1 for 3 cycles then back to 0 → no status, gpio_in_sync[7] unchanged. Hold high for 5 cycles → gpio_in_sync[7]=1 after 4 stable cycles, rising-edge status sets one cycle later.
